// File: rtl/md5_pkg.sv
// md5_pkg: shared MD5 constants (K, shift amounts, IV), message-index helper and working-state type
package md5_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } md5_state_t;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Shift amounts repeat every 4 steps within a round, so one row per round suffices.
    localparam logic [4:0] MD5_S [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [4:0] md5_s(input logic [5:0] i);
        return MD5_S[{i[5:4], i[1:0]}];
    endfunction

    function automatic logic [3:0] md5_g(input logic [5:0] i);
        return i[5:4] == 2'd0 ? i[3:0] :
               i[5:4] == 2'd1 ? 4'(5 * i + 1) :
               i[5:4] == 2'd2 ? 4'(3 * i + 5) :
                                4'(7 * i);
    endfunction

endpackage

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step
//   i_st  : working state a/b/c/d before the step
//   i_m   : selected message word M[g]
//   i_k   : round constant K[i]
//   i_s   : left-rotate amount s[i]
//   i_rnd : round select (0:F 1:G 2:H 3:I)
//   o_st  : working state after the step
module md5_step
    import md5_pkg::*;
(
    input  md5_state_t  i_st,
    input  logic [31:0] i_m,
    input  logic [31:0] i_k,
    input  logic [4:0]  i_s,
    input  logic [1:0]  i_rnd,
    output md5_state_t  o_st
);

    logic [31:0] w_f;
    logic [31:0] w_tmp;
    logic [31:0] w_rot;

    assign w_f = i_rnd == 2'd0 ? (i_st.b & i_st.c) | (~i_st.b & i_st.d) :
                 i_rnd == 2'd1 ? (i_st.d & i_st.b) | (~i_st.d & i_st.c) :
                 i_rnd == 2'd2 ? i_st.b ^ i_st.c ^ i_st.d :
                                 i_st.c ^ (i_st.b | ~i_st.d);

    assign w_tmp = i_st.a + w_f + i_k + i_m;
    // s is never 0, so the right shift by 32-s stays in range
    assign w_rot = (w_tmp << i_s) | (w_tmp >> (6'd32 - {1'b0, i_s}));
    assign o_st  = '{a: i_st.d, b: i_st.b + w_rot, c: i_st.b, d: i_st.c};

endmodule

// File: rtl/md5_update.sv
// md5_update: iterative MD5 compression of one 512-bit block (64 steps)
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   i_string     : message block, M[i] = i_string[32*i+31:32*i]
//   i_en         : start request, rising edge in IDLE starts a block
//   i_input_len  : byte count, carried for interface compatibility only
//   i_a..i_d     : chaining words, initial working a..d
//   o_complete   : toggles once per finished block
//   o_a..o_d     : final working a..d (caller adds chaining words)
// Define MD5_UNROLL2_EN to run two steps per clock (32 RUN cycles).
module md5_update
    import md5_pkg::*;
#(
`ifdef MD5_UNROLL2_EN
    parameter int ROUNDS_PER_CLK = 2
`else
    parameter int ROUNDS_PER_CLK = 1
`endif
)(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] i_string,
    input  logic         i_en,
    input  logic [8:0]   i_input_len,
    input  logic [31:0]  i_a,
    input  logic [31:0]  i_b,
    input  logic [31:0]  i_c,
    input  logic [31:0]  i_d,
    output logic         o_complete,
    output logic [31:0]  o_a,
    output logic [31:0]  o_b,
    output logic [31:0]  o_c,
    output logic [31:0]  o_d
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]   r_state;
    logic         r_en_q;
    logic [5:0]   r_i;
    logic [511:0] r_msg;
    md5_state_t   r_w;
    md5_state_t   r_out;
    logic         r_complete;

    logic         w_start;
    logic         w_last;
    logic         w_unused;
    logic [3:0]   w_g0;
    md5_state_t   w_s0;
    md5_state_t   w_next;

    assign w_unused = ^i_input_len;
    assign w_start  = i_en & ~r_en_q & (r_state == S_IDLE);
    assign w_last   = r_i == 6'(64 - ROUNDS_PER_CLK);
    assign w_g0     = md5_g(r_i);

    md5_step u_step0 (
        .i_st  (r_w),
        .i_m   (r_msg[32*w_g0 +: 32]),
        .i_k   (MD5_K[r_i]),
        .i_s   (md5_s(r_i)),
        .i_rnd (r_i[5:4]),
        .o_st  (w_s0)
    );

`ifdef MD5_UNROLL2_EN
    // r_i is always even here, so the second step index is r_i | 1
    logic [5:0] w_i1;
    logic [3:0] w_g1;
    md5_state_t w_s1;

    assign w_i1 = r_i | 6'd1;
    assign w_g1 = md5_g(w_i1);

    md5_step u_step1 (
        .i_st  (w_s0),
        .i_m   (r_msg[32*w_g1 +: 32]),
        .i_k   (MD5_K[w_i1]),
        .i_s   (md5_s(w_i1)),
        .i_rnd (w_i1[5:4]),
        .o_st  (w_s1)
    );

    assign w_next = w_s1;
`else
    assign w_next = w_s0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_en_q     <= 1'b0;
            r_i        <= '0;
            r_msg      <= '0;
            r_w        <= '0;
            r_out      <= '0;
            r_complete <= 1'b0;
        end else begin
            r_en_q <= i_en;
            if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_msg   <= i_string;
                    r_w     <= '{a: i_a, b: i_b, c: i_c, d: i_d};
                    r_i     <= '0;
                    r_state <= S_RUN;
                end
            end else begin
                r_w <= w_next;
                r_i <= r_i + 6'(ROUNDS_PER_CLK);
                if (w_last) begin
                    r_out      <= w_next;
                    r_complete <= ~r_complete;
                    r_state    <= S_IDLE;
                end
            end
        end
    end

    assign o_complete = r_complete;
    assign o_a        = r_out.a;
    assign o_b        = r_out.b;
    assign o_c        = r_out.c;
    assign o_d        = r_out.d;

endmodule

// File: tb/tb_md5_update.sv
// tb_md5_update: directed scoreboard bench for md5_update against a software MD5 model
module tb_md5_update;

    localparam int LAT = 64;
    localparam logic [31:0] IVA = 32'h67452301;
    localparam logic [31:0] IVB = 32'hefcdab89;
    localparam logic [31:0] IVC = 32'h98badcfe;
    localparam logic [31:0] IVD = 32'h10325476;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [511:0] i_string = '0;
    logic         i_en = 1'b0;
    logic [8:0]   i_input_len = '0;
    logic [31:0]  i_a = '0, i_b = '0, i_c = '0, i_d = '0;
    logic         o_complete;
    logic [31:0]  o_a, o_b, o_c, o_d;

    int n_chk = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];
    logic [31:0]  kt[64];
    int srow[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    md5_update dut (
        .clk(clk), .rst(rst), .i_string(i_string), .i_en(i_en), .i_input_len(i_input_len),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_d(i_d),
        .o_complete(o_complete), .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] md5_model(input logic [511:0] m, input logic [31:0] a0, b0, c0, d0);
        logic [31:0] a, b, c, d, f, t, r;
        int g;
        a = a0; b = b0; c = c0; d = d0;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
            else begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            t = a + f + kt[i] + m[32*g +: 32];
            r = (t << srow[(i / 16) * 4 + i % 4]) | (t >> (32 - srow[(i / 16) * 4 + i % 4]));
            a = d; d = c; c = b; b = b + r;
        end
        return {a, b, c, d};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts one block, waits for the toggle, checks latency and pops the scoreboard.
    task automatic run_block(input string tag, input logic [511:0] msg, input logic [31:0] ia, ib, ic, id,
                             input bit hold, input bit mangle, output logic [127:0] res);
        logic prev;
        int cnt;
        @(negedge clk);
        i_string = msg; i_a = ia; i_b = ib; i_c = ic; i_d = id; i_en = 1'b1;
        i_input_len = 9'($urandom_range(0, 64));
        exp_q.push_back(md5_model(msg, ia, ib, ic, id));
        prev = o_complete;
        @(posedge clk); #1;
        if (!hold) i_en = 1'b0;
        cnt = 0;
        while (o_complete === prev && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (mangle && cnt == 10) begin
                i_string = ~msg; i_a = ia ^ 32'hdeadbeef; i_input_len = 9'h1ff;
            end
        end
        check({tag, "_latency"}, 128'(cnt), 128'(LAT));
        res = {o_a, o_b, o_c, o_d};
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 128'(1), 128'(0));
        else check({tag, "_result"}, res, exp_q.pop_front());
    endtask

    function automatic logic [511:0] rand_msg();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    initial begin
        logic [511:0] msg, msg2;
        logic [127:0] res, res1, snap;
        int toggles;
        logic prev;
        for (int i = 0; i < 64; i++) kt[i] = 32'(longint'($floor((($sin(real'(i + 1)) < 0.0) ? -$sin(real'(i + 1)) : $sin(real'(i + 1))) * 4294967296.0)));

        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {o_a, o_b, o_c, o_d}, '0);
        check("reset_complete", 128'(o_complete), 128'(0));
        @(negedge clk) rst = 1'b1;

        msg = '0; msg[7] = 1'b1;
        run_block("empty", msg, IVA, IVB, IVC, IVD, 0, 0, res);
        check("empty_digest", {IVA + res[127:96], IVB + res[95:64], IVC + res[63:32], IVD + res[31:0]},
              128'hd98c1dd4_04b2008f_980980e9_7e42f8ec);
        check("empty_complete", 128'(o_complete), 128'(1));

        msg = '0; msg[31:0] = 32'h80636261; msg[455:448] = 8'h18;
        run_block("abc", msg, IVA, IVB, IVC, IVD, 0, 0, res);
        check("abc_digest", {IVA + res[127:96], IVB + res[95:64], IVC + res[63:32], IVD + res[31:0]},
              128'h98500190_b04fd23c_7d3f96d6_727fe128);

        run_block("hold", rand_msg(), IVA, IVB, IVC, IVD, 1, 0, res);
        snap = res;
        toggles = 0;
        prev = o_complete;
        repeat (200 - LAT) begin
            @(posedge clk); #1;
            if (o_complete !== prev) toggles++;
            prev = o_complete;
        end
        check("hold_no_retrigger", 128'(toggles), 128'(0));
        check("hold_outputs_stable", {o_a, o_b, o_c, o_d}, snap);
        @(negedge clk) i_en = 1'b0;

        @(negedge clk);
        i_string = rand_msg(); i_en = 1'b1;
        @(posedge clk); #1 i_en = 1'b0;
        repeat (29) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("abort_outputs", {o_a, o_b, o_c, o_d}, '0);
        check("abort_complete", 128'(o_complete), 128'(0));
        @(negedge clk) rst = 1'b1;
        run_block("after_abort", rand_msg(), $urandom, $urandom, $urandom, $urandom, 0, 0, res);

        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        msg = rand_msg();
        run_block("b2b_first", msg, IVA, IVB, IVC, IVD, 0, 0, res1);
        msg2 = rand_msg();
        run_block("b2b_second", msg2, IVA + res1[127:96], IVB + res1[95:64], IVC + res1[63:32], IVD + res1[31:0], 0, 0, res);
        check("b2b_complete_zero", 128'(o_complete), 128'(0));

        msg = rand_msg();
        run_block("clean_run", msg, IVA, IVB, IVC, IVD, 0, 0, res1);
        run_block("mangled_run", msg, IVA, IVB, IVC, IVD, 0, 1, res);
        check("mangle_identical", res, res1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/md5_update.md
Name:
md5_update

Overview:
- Iterative MD5 compression engine: applies the 64 MD5 steps to one 512-bit message block.
- Starts from a caller-supplied chaining state A/B/C/D and returns the final working variables a/b/c/d.
- The caller forms the new chaining value itself (A+a, B+b, C+c, D+d).
- Sits between the text-entry/padding controller (which builds padded blocks) and the digest-to-ASCII output logic.

Parameters:
- ROUNDS_PER_CLK, 1, MD5 steps per clock. Legal values: 1, or 2 when MD5_UNROLL2_EN is defined.

Ports:
- clk  input  1  system clock; all state on the rising edge
- rst  input  1  asynchronous, active-low reset
- string  input  512  message block; word M[i] = string[32*i+31:32*i] (i=0..15), little-endian bytes, byte k at string[8k+7:8k]
- en  input  1  start request (level); sampled every clock
- input_len  input  9  bytes in block; no functional effect, interface compatibility only
- A  input  32  chaining word A (initial a)
- B  input  32  chaining word B
- C  input  32  chaining word C
- D  input  32  chaining word D
- complete  output  1  done toggle; flips once per finished block
- a  output  32  final working a after step 63 (not added to A)
- b  output  32  final working b
- c  output  32  final working c
- d  output  32  final working d

Behaviour:
- Reset (rst=0, async): a=b=c=d=0, complete=0, state IDLE, step counter=0, en_q=0.
- en_q registers en every cycle. start = en & ~en_q & (state==IDLE). Start is rising-edge triggered: a level held high after done does not restart.
- IDLE: on start, latch string into the message register, latch A..D into working regs wa..wd, clear step counter i, go RUN.
- RUN, one step per clock (i=0..63):
  - Round function: F=(b&c)|(~b&d), i<16; G=(d&b)|(~d&c), i<32; H=b^c^d, i<48; I=c^(b|~d) otherwise.
  - Message index g: i for i<16; (5i+1) mod 16 for i<32; (3i+5) mod 16 for i<48; 7i mod 16 otherwise.
  - tmp = wa + f + K[i] + M[g], all mod 2^32.
  - Update: wa<=wd; wd<=wc; wc<=wb; wb<=wb + (tmp <<< s[i]).
  - K[i] = floor(|sin(i+1)|*2^32). s rows: {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}, each repeated 4 times per 16 steps.
- On the clock that executes step 63: the a..d outputs take the post-step values, complete toggles, state returns to IDLE.
- Latency: start sampled at edge N; complete toggles at edge N+64 (N+32 when unrolled).
- Outputs hold until the next completion. Changes on string, A..D or input_len during RUN are ignored (captured at start).
- A rising edge of en during RUN is ignored. en must fall and rise again after IDLE is re-entered.
- Reset during RUN aborts with no toggle.

Optional Feature:
- MD5_UNROLL2_EN defined: two chained step instances per clock; ROUNDS_PER_CLK=2; 32 RUN cycles; results bit-identical.
- Undefined: one step per clock; ROUNDS_PER_CLK must be 1.

Decomposition:
- Package md5_pkg: K[0..63] constant array, shift table s[0..63], message-index function, IV constants 67452301/efcdab89/98badcfe/10325476.
- Sub-module md5_step: combinational single step, taking (wa..wd, M[g], K, s, round select) and returning the new (wa..wd).
- Top module: FSM, counter, registers; instantiates md5_step once, or twice under MD5_UNROLL2_EN.

Test Plan:
- Empty message: string with only string[7]=1, A..D=IV; pulse en. Required: complete toggles after 64 cycles; A+a=d98c1dd4, B+b=04b2008f, C+c=980980e9, D+d=7e42f8ec (digest d41d8cd98f00b204e9800998ecf8427e).
- "abc": string[31:0]=80636261, string[455:448]=18, rest 0, IV. Required: A+a=98500190, B+b=b04fd23c, C+c=7d3f96d6, D+d=727fe128.
- Level hold: en held high 200 cycles. Required: exactly one toggle, outputs stable afterwards.
- Back-to-back: second block started from the chaining words of the first. Required: complete returns to 0 after two blocks; outputs match software model.
- Reset asserted at step 30. Required: a..d=0, complete=0 immediately; next en edge runs a full 64-step computation.
- Input change mid-run: alter string and A at step 10. Required: result identical to the unaltered run.
